// File: rtl/stuffing_tx_fd_pkg.sv
// Shared constants and helpers for the CAN/CAN-FD bit stuffer and de-stuffer.
package stuffing_tx_fd_pkg;

  localparam int RUN_LEN_DEF      = 5;
  localparam int FIXED_PERIOD_DEF = 4;

  typedef enum logic {
    MODE_DYN = 1'b0,
    MODE_FD  = 1'b1
  } tx_mode_e;

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic even_parity(input logic [2:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/edge_det_rise.sv
// Rising-edge detector: one pulse on the first clock a level strobe is seen high.
module edge_det_rise (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/stuffing_tx_fd.sv
// Transmit bit stuffer: dynamic stuffing after RUN_LEN equal bits, fixed stuffing in the FD CRC field.
//   state    | meaning
//   MODE_DYN | dynamic stuffing, run counter live
//   MODE_FD  | FD CRC field, fixed stuff every FIXED_PERIOD bits, run/stuff counters frozen
module stuffing_tx_fd
  import stuffing_tx_fd_pkg::*;
#(
  parameter int RUN_LEN      = RUN_LEN_DEF,
  parameter int FIXED_PERIOD = FIXED_PERIOD_DEF,
  parameter int CNT_W        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bitin,
  input  logic       activ,
  input  logic       direct,
  input  logic       setdom,
  input  logic       setrec,
  input  logic       fd_crc,
  output logic       bitout,
  output logic       stuff,
  output logic       take,
  output logic [2:0] stfcnt_gray,
  output logic       stfcnt_par
);

  tx_mode_e         state, state_n;
  logic             action;
  logic             stuff_path;
  logic [CNT_W-1:0] count, count_n, cnt_eff;
  logic [CNT_W-1:0] fcnt, fcnt_n;
  logic [2:0]       scnt, scnt_n;
  logic             last, last_n;
  logic             bitout_n, stuff_n, take_n;

  edge_det_rise u_edge (
    .clock (clock),
    .reset (reset),
    .d     (activ),
    .pulse (action)
  );

  assign stuff_path = action & ~direct & ~setdom & ~setrec;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MODE_DYN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (stuff_path) state_n = fd_crc ? MODE_FD : MODE_DYN;
  end

  // Leaving FD restarts the run, so the first dynamic bit sees an empty counter.
  assign cnt_eff = (state == MODE_FD) ? '0 : count;

  always_comb begin
    bitout_n = bitout;
    stuff_n  = stuff;
    take_n   = take;
    count_n  = count;
    last_n   = last;
    fcnt_n   = fcnt;
    scnt_n   = scnt;
    if (action) begin
      stuff_n = 1'b0;
      take_n  = 1'b0;
      if (direct) begin
        bitout_n = bitin;
        take_n   = 1'b1;
      end else if (setdom) begin
        bitout_n = 1'b0;
      end else if (setrec) begin
        bitout_n = 1'b1;
      end else if (fd_crc) begin
        if (state == MODE_DYN || fcnt == CNT_W'(FIXED_PERIOD)) begin
          bitout_n = ~last;
          stuff_n  = 1'b1;
          fcnt_n   = '0;
        end else begin
          bitout_n = bitin;
          take_n   = 1'b1;
          last_n   = bitin;
          fcnt_n   = fcnt + CNT_W'(1);
        end
      end else if (cnt_eff == CNT_W'(RUN_LEN)) begin
        bitout_n = ~last;
        last_n   = ~last;
        count_n  = CNT_W'(1);
        stuff_n  = 1'b1;
        scnt_n   = scnt + 3'd1;
      end else if (cnt_eff == '0 || bitin != last) begin
        bitout_n = bitin;
        take_n   = 1'b1;
        last_n   = bitin;
        count_n  = CNT_W'(1);
      end else begin
        bitout_n = bitin;
        take_n   = 1'b1;
        count_n  = cnt_eff + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitout <= 1'b1;
      stuff  <= 1'b0;
      take   <= 1'b0;
      count  <= '0;
      last   <= 1'b0;
      fcnt   <= '0;
      scnt   <= '0;
    end else begin
      bitout <= bitout_n;
      stuff  <= stuff_n;
      take   <= take_n;
      count  <= count_n;
      last   <= last_n;
      fcnt   <= fcnt_n;
      scnt   <= scnt_n;
    end
  end

  assign stfcnt_gray = bin2gray(scnt);
  assign stfcnt_par  = even_parity(bin2gray(scnt));

endmodule

// File: tb/tb_stuffing_tx_fd.sv
// Self-checking bench for stuffing_tx_fd: directed scenarios plus randomized traffic against a behavioural model.
module tb_stuffing_tx_fd;

  localparam int RL = 5;
  localparam int FP = 4;

  logic       clock = 1'b0;
  logic       reset, bitin, activ, direct, setdom, setrec, fd_crc;
  logic       bitout, stuff, take, stfcnt_par;
  logic [2:0] stfcnt_gray;

  always #5 clock = ~clock;

  stuffing_tx_fd #(.RUN_LEN(RL), .FIXED_PERIOD(FP), .CNT_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .bitin       (bitin),
    .activ       (activ),
    .direct      (direct),
    .setdom      (setdom),
    .setrec      (setrec),
    .fd_crc      (fd_crc),
    .bitout      (bitout),
    .stuff       (stuff),
    .take        (take),
    .stfcnt_gray (stfcnt_gray),
    .stfcnt_par  (stfcnt_par)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: run length of equal transmitted bits, previous bit, FD state, bits since fixed stuff, total dynamic stuffs.
  int m_run, m_last, m_in_fd, m_since_fix, m_nstuff;
  int m_bitout, m_stuff, m_take;

  function automatic void model_reset();
    m_run = 0; m_last = 0; m_in_fd = 0; m_since_fix = 0; m_nstuff = 0;
    m_bitout = 1; m_stuff = 0; m_take = 0;
  endfunction

  function automatic void model_step(int b, int dir, int dom, int rec, int fd);
    m_stuff = 0; m_take = 0;
    if (dir != 0) begin
      m_bitout = b; m_take = 1;
    end else if (dom != 0) begin
      m_bitout = 0;
    end else if (rec != 0) begin
      m_bitout = 1;
    end else if (fd != 0) begin
      if (m_in_fd == 0 || m_since_fix == FP) begin
        m_bitout = 1 - m_last; m_stuff = 1; m_since_fix = 0; m_in_fd = 1;
      end else begin
        m_bitout = b; m_take = 1; m_last = b; m_since_fix++;
      end
    end else begin
      if (m_in_fd != 0) begin m_run = 0; m_in_fd = 0; end
      if (m_run == RL) begin
        m_last = 1 - m_last; m_bitout = m_last; m_run = 1; m_stuff = 1; m_nstuff++;
      end else if (m_run == 0 || b != m_last) begin
        m_bitout = b; m_take = 1; m_last = b; m_run = 1;
      end else begin
        m_bitout = b; m_take = 1; m_run++;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int s, g;
    s = m_nstuff % 8;
    g = s ^ (s >> 1);
    check({tag, ".bitout"}, {3'b0, bitout}, 4'(m_bitout));
    check({tag, ".stuff"},  {3'b0, stuff},  4'(m_stuff));
    check({tag, ".take"},   {3'b0, take},   4'(m_take));
    check({tag, ".gray"},   {1'b0, stfcnt_gray}, 4'(g));
    check({tag, ".par"},    {3'b0, stfcnt_par},  4'($countones(g) % 2));
  endtask

  task automatic act(input string tag, input int b, input int dir, input int dom, input int rec, input int fd);
    @(negedge clock);
    bitin = b[0]; direct = dir[0]; setdom = dom[0]; setrec = rec[0]; fd_crc = fd[0];
    activ = 1'b1;
    model_step(b, dir, dom, rec, fd);
    @(negedge clock);
    check(tag, {3'b0, bitout}, 4'(m_bitout));
    activ = 1'b0;
    @(negedge clock);
    check_all({tag, ".hold"});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    activ = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int r, b, dir, dom, rec, fd, guard;
    reset = 1'b1; activ = 1'b0; bitin = 1'b0; direct = 1'b0;
    setdom = 1'b0; setrec = 1'b0; fd_crc = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset = 1'b0;

    // Five zeros then a stuff bit of one.
    for (int i = 0; i < 5; i++) act("z5", 0, 0, 0, 0, 0);
    act("z5_stuff", 0, 0, 0, 0, 0);
    check("z5.stuff_const", {3'b0, stuff}, 4'd1);
    check("z5.bitout_const", {3'b0, bitout}, 4'd1);
    check("z5.gray_const", {1'b0, stfcnt_gray}, 4'b0001);

    // Ten ones: stuffs after the 5th and the 10th data bit.
    do_reset("rst_ones");
    for (int i = 0; i < 12; i++) act("ones", 1, 0, 0, 0, 0);
    check("ones.gray_const", {1'b0, stfcnt_gray}, 4'b0011);
    check("ones.par_const", {3'b0, stfcnt_par}, 4'd0);

    // setdom does not disturb the run.
    do_reset("rst_dom");
    for (int i = 0; i < 4; i++) act("dom_run", 0, 0, 0, 0, 0);
    act("dom", 0, 0, 1, 0, 0);
    check("dom.bitout_const", {3'b0, bitout}, 4'd0);
    act("dom_5th", 0, 0, 0, 0, 0);
    check("dom_5th.stuff_const", {3'b0, stuff}, 4'd0);
    act("dom_stuff", 0, 0, 0, 0, 0);
    check("dom_stuff.stuff_const", {3'b0, stuff}, 4'd1);
    check("dom_stuff.bitout_const", {3'b0, bitout}, 4'd1);

    // FD entry stuff, four data bits, fixed stuff, then back to dynamic.
    do_reset("rst_fd");
    act("fd_pre", 1, 0, 0, 0, 0);
    act("fd_entry", 1, 0, 0, 0, 1);
    check("fd_entry.bitout_const", {3'b0, bitout}, 4'd0);
    check("fd_entry.stuff_const", {3'b0, stuff}, 4'd1);
    act("fd_d0", 1, 0, 0, 0, 1);
    act("fd_d1", 0, 0, 0, 0, 1);
    act("fd_d2", 1, 0, 0, 0, 1);
    act("fd_d3", 1, 0, 0, 0, 1);
    check("fd_d3.take_const", {3'b0, take}, 4'd1);
    act("fd_fix", 1, 0, 0, 0, 1);
    check("fd_fix.bitout_const", {3'b0, bitout}, 4'd0);
    check("fd_fix.stuff_const", {3'b0, stuff}, 4'd1);
    for (int i = 0; i < 6; i++) act("fd_exit", 1, 0, 0, 0, 0);

    // Reset mid-run aborts the pending stuff.
    do_reset("rst_mid0");
    for (int i = 0; i < 4; i++) act("mid_pre", 1, 0, 0, 0, 0);
    do_reset("rst_mid");
    check("rst_mid.bitout_const", {3'b0, bitout}, 4'd1);
    for (int i = 0; i < 4; i++) begin
      act("mid_post", 1, 0, 0, 0, 0);
      check("mid_post.nostuff", {3'b0, stuff}, 4'd0);
    end

    // activ held high for 20 cycles yields exactly one action.
    do_reset("rst_hold");
    for (int i = 0; i < 5; i++) act("hold_pre", 1, 0, 0, 0, 0);
    @(negedge clock);
    bitin = 1'b1; activ = 1'b1;
    model_step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_all("hold20");
    end
    activ = 1'b0;

    // Drive equal bits until nine dynamic stuffs: counter wraps to 1.
    guard = 0;
    while (m_nstuff < 9 && guard < 200) begin
      act("wrap", m_last, 0, 0, 0, 0);
      guard++;
    end
    check("wrap.budget", 4'(guard < 200), 4'd1);
    check("wrap.gray_const", {1'b0, stfcnt_gray}, 4'b0001);
    check("wrap.par_const", {3'b0, stfcnt_par}, 4'd1);

    // Randomized traffic.
    fd = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      if ($urandom_range(0, 19) == 0) fd = 1 - fd;
      b = ($urandom_range(0, 99) < 75) ? m_last : int'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      dir = (r < 4) ? 1 : 0;
      dom = (r >= 4 && r < 8) ? 1 : 0;
      rec = (r >= 8 && r < 12) ? 1 : 0;
      act("rnd", b, dir, dom, rec, fd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
